// File: rtl/sha256_round_sequencer.sv
// SHA-256 compression controller: sequences LOAD/ROUND/FINAL and holds a..h and H0..H7.
// The T1/T2 arithmetic lives outside the block. This block shifts the working words and adds the chaining value back in.
module sha256_round_sequencer #(
  parameter int ROUNDS = 64
) (
  input  logic         i_clkm,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_abort,
  input  logic [255:0] i_hash_in,
  output logic         o_busy,
  output logic         o_done,
  output logic [255:0] o_digest,
  output logic [5:0]   o_round,
  input  logic         i_w_valid,
  input  logic [31:0]  i_w_data,
  output logic         o_w_ready,
  output logic [255:0] o_working,
  input  logic [31:0]  i_t1,
  input  logic [31:0]  i_t2
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ROUND, S_FINAL} state_t;

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [5:0]    r_round;
  logic          r_done;
  logic [255:0]  r_digest;
  logic [31:0]   r_work [8];
  logic [31:0]   r_hash [8];
  logic [31:0]   w_h_in [8];
  logic [31:0]   w_sum  [8];
  logic          w_accept;
  logic          w_unused;

  // W_t itself is only observed by the external datapath.
  assign w_unused = ^i_w_data;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word
      assign o_working[255-32*gi -: 32] = r_work[gi];
      assign w_h_in[gi]                 = i_hash_in[255-32*gi -: 32];
      assign w_sum[gi]                  = r_hash[gi] + r_work[gi];
    end
  endgenerate

  assign w_accept  = (r_state == S_ROUND) && i_w_valid && !i_abort;
  assign o_busy    = (r_state != S_IDLE);
  assign o_w_ready = (r_state == S_ROUND);
  assign o_round   = (r_state == S_ROUND) ? r_round : 6'd0;
  assign o_done    = r_done;
  assign o_digest  = r_digest;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_next = S_LOAD;
      S_LOAD:  w_state_next = S_ROUND;
      S_ROUND: if (w_accept && (r_round == LAST_ROUND)) w_state_next = S_FINAL;
      S_FINAL: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Abort overrides everything, including start in IDLE.
    if (i_abort) w_state_next = S_IDLE;
  end

  always_ff @(posedge i_clkm or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_round  <= 6'd0;
      r_done   <= 1'b0;
      r_digest <= '0;
      for (int i = 0; i < 8; i++) begin
        r_work[i] <= '0;
        r_hash[i] <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_done  <= (r_state == S_FINAL) && !i_abort;

      if ((r_state == S_LOAD) && !i_abort) begin
        r_round <= 6'd0;
        for (int i = 0; i < 8; i++) begin
          r_hash[i] <= w_h_in[i];
          r_work[i] <= w_h_in[i];
        end
      end

      if (w_accept) begin
        r_round   <= r_round + 6'd1;
        r_work[0] <= i_t1 + i_t2;
        r_work[1] <= r_work[0];
        r_work[2] <= r_work[1];
        r_work[3] <= r_work[2];
        r_work[4] <= r_work[3] + i_t1;
        r_work[5] <= r_work[4];
        r_work[6] <= r_work[5];
        r_work[7] <= r_work[6];
      end

      if ((r_state == S_FINAL) && !i_abort) begin
        for (int i = 0; i < 8; i++) begin
          r_digest[255-32*i -: 32] <= w_sum[i];
        end
      end
    end
  end

endmodule
